trap_monitor: RTL and testbench
===============================

# trap_monitor

Parametrised end-of-simulation monitor for the NPC core. It watches up to NCH commit channels and detects `ebreak`, illegal-opcode and overflow traps, plus a no-commit watchdog. It latches the first trap's PC, cause and exit code, then drains and halts. It also keeps cycle/instret counters, and sits beside the core top alongside the difftest hooks.

## Interface
- NCH, 1 — number of commit channels; channel 0 is oldest in program order
- XLEN, 32 — PC/register width
- TIMEOUT, 1000000 — consecutive no-commit cycles before a timeout trap; 0 disables the watchdog
- DRAIN_CYCLES, 2 — cycles spent in DRAIN before HALTED; minimum 1

- clk  in  1  — core clock
- rst  in  1  — synchronous, active-low reset
- commit_valid  in  NCH  — channel i retires an instruction this cycle
- commit_pc  in  NCH*XLEN  — PC per channel; channel i is bits [i*XLEN +: XLEN]
- commit_inst  in  NCH*32  — instruction word per channel
- commit_ovf  in  NCH  — arithmetic overflow flagged by channel i
- a0  in  XLEN  — architectural x10 value, valid for the committing `ebreak`
- halt  out  1  — a trap has been accepted (DRAIN or HALTED)
- done  out  1  — state is HALTED
- halt_good  out  1  — accepted trap is cause GOOD
- halt_cause  out  3  — trap cause code
- halt_pc  out  XLEN  — PC of the trapping instruction
- halt_code  out  XLEN  — a0 at `ebreak`, otherwise 1
- cycle_cnt  out  64  — cycles spent in RUN
- instret_cnt  out  64  — instructions retired in RUN, excluding the trapping one

## Operation
- Cause codes:
  - 0 NONE
  - 1 GOOD: `ebreak` with a0==0
  - 2 BAD_CODE: `ebreak` with a0!=0
  - 3 ILLEGAL: inst[6:0]==7'b1111111
  - 4 OVERFLOW: commit_ovf
  - 5 TIMEOUT
- `ebreak` is matched on the exact word 32'h00100073.
- Per-channel priority, applied only when commit_valid[i] is high:
  - `ebreak` first
  - then overflow
  - then illegal
- Across channels, the lowest-index trapping channel wins.
  - Valid channels below the winner count toward instret.
  - The winner and all higher channels do not count.
- FSM states:
  - RUN → DRAIN when any channel traps, or when idle_cnt==TIMEOUT (TIMEOUT≠0).
  - DRAIN → HALTED after DRAIN_CYCLES cycles in DRAIN.
  - HALTED is sticky until reset.
- The watchdog idle counter clears on any valid commit and increments otherwise, in RUN only.
- A channel trap in the same cycle the watchdog expires wins over TIMEOUT.
- TIMEOUT latch values: halt_pc = most recent committed PC (0 if none), halt_code = 1.
- Outside RUN:
  - all commit inputs are ignored
  - counters freeze
  - halt_* fields hold their values
- Counters wrap modulo 2^64.

## Timing
- Reset: state RUN, every output 0, idle counter 0. Reset applies on any clk edge with rst low, including in DRAIN or HALTED, and returns the block to RUN with all fields cleared.
- Trap latency:
  - halt, halt_cause, halt_pc, halt_code and halt_good are valid on the cycle after the trapping commit edge, i.e. the first DRAIN cycle.
  - done rises DRAIN_CYCLES cycles after halt.
- Counter timing:
  - cycle_cnt increments on every RUN cycle, including the trap cycle.
  - instret_cnt is updated on the same edge as the trap latch.
- All outputs are registered; none depends combinationally on inputs.

## Configuration
- TRAP_SIM_FINISH_EN defined:
  - On the DRAIN→HALTED edge, a non-synthesisable block prints a banner with the cause name, halt_pc, halt_code, cycle_cnt and instret_cnt.
  - It prints green "HIT GOOD TRAP" for cause GOOD and red "HIT BAD TRAP" for all others.
  - It then calls $finish with 0 for GOOD and 1 otherwise.
- TRAP_SIM_FINISH_EN undefined:
  - No system tasks.
  - The block is fully synthesisable and the harness polls done/halt_good.

## Structure
- Package trap_pkg holds:
  - cause enum (3-bit)
  - FSM state enum
  - EBREAK_INST constant
  - ILLEGAL_OPCODE constant
- Sub-module trap_decode (combinational, instantiated NCH times) takes valid/inst/ovf/a0 and produces trap_hit and cause.
  - trap_decode receives the shared a0 input; only the `ebreak`-detecting channel uses it for the GOOD/BAD_CODE distinction.
- The priority pick, FSM, watchdog and counters live in trap_monitor.

## Test plan
- NCH=1: 5 normal commits, then `ebreak` at PC 0x80000014 with a0=0 → next cycle:
  - halt=1, cause 1, halt_good=1, halt_pc=0x80000014
  - instret_cnt=5
  - done after 2 cycles; exit status 0 with the macro defined
- `ebreak` with a0=0x2A → cause 2, halt_code=0x2A, halt_good=0, exit 1.
- NCH=2, same cycle: ch0 valid normal, ch1 inst 0x0000007F → cause 3, halt_pc=ch1 PC, instret increments by 1. Repeat with ch0 illegal and ch1 `ebreak` → cause 3, ch0 PC.
- TIMEOUT=8, no commits after reset → cause 5 in the 9th cycle, halt_pc=0, halt_code=1. Same run with a commit at cycle 6 → no trap before cycle 15.
- Overflow and illegal on the same channel → cause 4. Further commits after halt change no output or counter.
- Assert rst low during DRAIN → next cycle all outputs 0, state RUN, counters restart from 0.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared types and constants for the trap monitor: cause codes, FSM states,
// and the instruction patterns that the per-channel decoder matches.
package trap_pkg;

  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_GOOD     = 3'd1,
    CAUSE_BAD_CODE = 3'd2,
    CAUSE_ILLEGAL  = 3'd3,
    CAUSE_OVERFLOW = 3'd4,
    CAUSE_TIMEOUT  = 3'd5
  } cause_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [31:0] EBREAK_INST    = 32'h0010_0073;
  localparam logic [6:0]  ILLEGAL_OPCODE = 7'b111_1111;

endpackage

// File: rtl/trap_monitor_if.sv
// Commit-side bus into the trap monitor and its halt/counter status back out.
// The core (or harness) drives the master side; the monitor is the slave.
interface trap_monitor_if #(
    parameter int NCH  = 1,
    parameter int XLEN = 32
);
    logic [NCH-1:0]      commit_valid;
    logic [NCH*XLEN-1:0] commit_pc;
    logic [NCH*32-1:0]   commit_inst;
    logic [NCH-1:0]      commit_ovf;
    logic [XLEN-1:0]     a0;

    logic                halt;
    logic                done;
    logic                halt_good;
    logic [2:0]          halt_cause;
    logic [XLEN-1:0]     halt_pc;
    logic [XLEN-1:0]     halt_code;
    logic [63:0]         cycle_cnt;
    logic [63:0]         instret_cnt;

    modport master (
        output commit_valid, commit_pc, commit_inst, commit_ovf, a0,
        input  halt, done, halt_good, halt_cause, halt_pc, halt_code,
               cycle_cnt, instret_cnt
    );

    modport slave (
        input  commit_valid, commit_pc, commit_inst, commit_ovf, a0,
        output halt, done, halt_good, halt_cause, halt_pc, halt_code,
               cycle_cnt, instret_cnt
    );
endinterface

// File: rtl/trap_decode.sv
// Per-channel trap classifier. Priority within a channel is
// ebreak, then overflow, then illegal opcode; idle channels never trap.
module trap_decode
    import trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            valid,
    input  logic [31:0]     inst,
    input  logic            ovf,
    input  logic [XLEN-1:0] a0,
    output logic            trap_hit,
    output cause_e          cause
);

    always_comb begin
        trap_hit = 1'b0;
        cause    = CAUSE_NONE;
        if (valid) begin
            if (inst == EBREAK_INST) begin
                trap_hit = 1'b1;
                cause    = (a0 == '0) ? CAUSE_GOOD : CAUSE_BAD_CODE;
            end else if (ovf) begin
                trap_hit = 1'b1;
                cause    = CAUSE_OVERFLOW;
            end else if (inst[6:0] == ILLEGAL_OPCODE) begin
                trap_hit = 1'b1;
                cause    = CAUSE_ILLEGAL;
            end
        end
    end

endmodule

// File: rtl/trap_monitor.sv
// End-of-simulation trap monitor: latches the first trap, drains, then halts.
// Define TRAP_SIM_FINISH_EN to print a banner and $finish on entering HALTED.
module trap_monitor
    import trap_pkg::*;
#(
    parameter int NCH          = 1,
    parameter int XLEN         = 32,
    parameter int TIMEOUT      = 1000000,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    trap_monitor_if.slave  bus
);

    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int CW = $clog2(NCH + 1);
    localparam logic [IW-1:0] TIMEOUT_V    = IW'(TIMEOUT);
    localparam logic [DW-1:0] DRAIN_LAST_V = DW'(DRAIN_CYCLES - 1);

    logic [NCH-1:0]      valid;
    logic [NCH*XLEN-1:0] pc;
    logic [NCH*32-1:0]   inst;
    logic [NCH-1:0]      ovf;
    logic [XLEN-1:0]     a0;

    assign valid = bus.commit_valid;
    assign pc    = bus.commit_pc;
    assign inst  = bus.commit_inst;
    assign ovf   = bus.commit_ovf;
    assign a0    = bus.a0;

    logic [NCH-1:0] lane_hit;
    cause_e         lane_cause [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        trap_decode #(.XLEN(XLEN)) u_dec (
            .valid    (valid[g]),
            .inst     (inst[g*32 +: 32]),
            .ovf      (ovf[g]),
            .a0       (a0),
            .trap_hit (lane_hit[g]),
            .cause    (lane_cause[g])
        );
    end

    state_e          state_q, state_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic [XLEN-1:0] last_pc_q, last_pc_d;
    logic [63:0]     cycle_q, cycle_d;
    logic [63:0]     instret_q, instret_d;
    cause_e          cause_q, cause_d;
    logic [XLEN-1:0] hpc_q, hpc_d;
    logic [XLEN-1:0] hcode_q, hcode_d;
    logic            halt_q, halt_d;
    logic            done_q, done_d;
    logic            good_q, good_d;

    // Lowest-index trapping channel wins; only older valid channels retire.
    logic            trap_any;
    cause_e          win_cause;
    logic [XLEN-1:0] win_pc;
    logic [XLEN-1:0] win_code;
    logic [CW-1:0]   ret_cnt;
    logic [XLEN-1:0] commit_pc_last;
    logic            wd_fire;

    always_comb begin
        trap_any       = 1'b0;
        win_cause      = CAUSE_NONE;
        win_pc         = '0;
        win_code       = XLEN'(1);
        ret_cnt        = '0;
        commit_pc_last = last_pc_q;
        for (int i = 0; i < NCH; i++) begin
            if (!trap_any) begin
                if (lane_hit[i]) begin
                    trap_any  = 1'b1;
                    win_cause = lane_cause[i];
                    win_pc    = pc[i*XLEN +: XLEN];
                    if (lane_cause[i] == CAUSE_GOOD || lane_cause[i] == CAUSE_BAD_CODE)
                        win_code = a0;
                end else if (valid[i]) begin
                    ret_cnt = ret_cnt + CW'(1);
                end
            end
            if (valid[i]) commit_pc_last = pc[i*XLEN +: XLEN];
        end
    end

    assign wd_fire = (TIMEOUT != 0) && (idle_q == TIMEOUT_V);

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (trap_any || wd_fire) state_d = ST_DRAIN;
            ST_DRAIN:  if (drain_q == DRAIN_LAST_V) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        idle_d    = idle_q;
        drain_d   = '0;
        last_pc_d = last_pc_q;
        cycle_d   = cycle_q;
        instret_d = instret_q;
        cause_d   = cause_q;
        hpc_d     = hpc_q;
        hcode_d   = hcode_q;
        if (state_q == ST_RUN) begin
            cycle_d   = cycle_q + 64'd1;
            instret_d = instret_q + 64'(ret_cnt);
            last_pc_d = commit_pc_last;
            if (TIMEOUT != 0) idle_d = (|valid) ? '0 : idle_q + IW'(1);
            if (trap_any) begin
                cause_d = win_cause;
                hpc_d   = win_pc;
                hcode_d = win_code;
            end else if (wd_fire) begin
                cause_d = CAUSE_TIMEOUT;
                hpc_d   = commit_pc_last;
                hcode_d = XLEN'(1);
            end
        end
        if (state_q == ST_DRAIN) drain_d = drain_q + DW'(1);
        halt_d = (state_d != ST_RUN);
        done_d = (state_d == ST_HALTED);
        good_d = (cause_d == CAUSE_GOOD);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idle_q    <= '0;
            drain_q   <= '0;
            last_pc_q <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
            cause_q   <= CAUSE_NONE;
            hpc_q     <= '0;
            hcode_q   <= '0;
            halt_q    <= 1'b0;
            done_q    <= 1'b0;
            good_q    <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            drain_q   <= drain_d;
            last_pc_q <= last_pc_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            cause_q   <= cause_d;
            hpc_q     <= hpc_d;
            hcode_q   <= hcode_d;
            halt_q    <= halt_d;
            done_q    <= done_d;
            good_q    <= good_d;
        end
    end

    assign bus.halt        = halt_q;
    assign bus.done        = done_q;
    assign bus.halt_good   = good_q;
    assign bus.halt_cause  = cause_q;
    assign bus.halt_pc     = hpc_q;
    assign bus.halt_code   = hcode_q;
    assign bus.cycle_cnt   = cycle_q;
    assign bus.instret_cnt = instret_q;

`ifdef TRAP_SIM_FINISH_EN
    always @(posedge clk) begin
        if (rst && state_q == ST_DRAIN && state_d == ST_HALTED) begin
            if (cause_q == CAUSE_GOOD)
                $display("\033[1;32mHIT GOOD TRAP\033[0m cause=%s pc=%h code=%h cycles=%0d instret=%0d",
                         cause_q.name(), hpc_q, hcode_q, cycle_q, instret_q);
            else
                $display("\033[1;31mHIT BAD TRAP\033[0m cause=%s pc=%h code=%h cycles=%0d instret=%0d",
                         cause_q.name(), hpc_q, hcode_q, cycle_q, instret_q);
            if (cause_q == CAUSE_GOOD) $finish(0);
            else                       $finish(1);
        end
    end
`else
`endif

endmodule

// File: tb/tb_trap_monitor.sv
// Scoreboard bench for trap_monitor (NCH=2, TIMEOUT=8, DRAIN_CYCLES=2):
// directed traps push their expected latch; a monitor checks each halt rise.
module tb_trap_monitor;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] EBRK = 32'h0010_0073;
    localparam logic [31:0] ILL  = 32'h0000_007F;

    typedef struct {
        logic [2:0]  cause;
        logic [31:0] pc;
        logic [31:0] code;
        logic        good;
        logic [63:0] instret;
        logic [63:0] cycles;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    trap_monitor_if #(.NCH(2), .XLEN(32)) bus ();

    trap_monitor #(.NCH(2), .XLEN(32), .TIMEOUT(8), .DRAIN_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Monitor: compare the latched trap on each halt rise, and done latency.
    int   edge_cnt = 0;
    int   halt_at  = 0;
    logic halt_prev = 1'b0;
    logic done_prev = 1'b0;
    always @(posedge clk) edge_cnt++;

    always @(negedge clk) begin
        if (bus.halt && !halt_prev) begin
            halt_at = edge_cnt;
            if (exp_q.size() == 0) begin
                chk("unexpected_halt", 64'(bus.halt_cause), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("cause",   64'(bus.halt_cause), 64'(e.cause));
                chk("pc",      64'(bus.halt_pc),    64'(e.pc));
                chk("code",    64'(bus.halt_code),  64'(e.code));
                chk("good",    64'(bus.halt_good),  64'(e.good));
                chk("instret", bus.instret_cnt,     e.instret);
                chk("cycles",  bus.cycle_cnt,       e.cycles);
                chk("done_at_halt", 64'(bus.done),  64'd0);
            end
        end
        if (bus.done && !done_prev)
            chk("done_latency", 64'(edge_cnt - halt_at), 64'd2);
        halt_prev = bus.halt;
        done_prev = bus.done;
    end

    task automatic idle_inputs();
        bus.commit_valid = '0;
        bus.commit_pc    = '0;
        bus.commit_inst  = '0;
        bus.commit_ovf   = '0;
        bus.a0           = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // One RUN edge with the given commits; inputs return to idle afterwards.
    task automatic cyc(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] i0,
                       input logic o0, input logic [31:0] pc1, input logic [31:0] i1,
                       input logic o1, input logic [31:0] a);
        bus.commit_valid = v;
        bus.commit_pc    = {pc1, pc0};
        bus.commit_inst  = {i1, i0};
        bus.commit_ovf   = {o1, o0};
        bus.a0           = a;
        @(posedge clk);
        #1 idle_inputs();
    endtask

    task automatic push(input logic [2:0] c, input logic [31:0] p, input logic [31:0] k,
                        input logic g, input logic [63:0] ir, input logic [63:0] cy);
        exp_t e;
        e.cause = c; e.pc = p; e.code = k; e.good = g; e.instret = ir; e.cycles = cy;
        exp_q.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && !bus.done; i++) @(negedge clk);
        chk("done_reached", 64'(bus.done), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        do_reset();
        @(negedge clk);
        chk("rst_halt",    64'(bus.halt),       64'd0);
        chk("rst_done",    64'(bus.done),       64'd0);
        chk("rst_cause",   64'(bus.halt_cause), 64'd0);
        chk("rst_pc",      64'(bus.halt_pc),    64'd0);
        chk("rst_code",    64'(bus.halt_code),  64'd0);
        chk("rst_cycles",  bus.cycle_cnt,       64'd0);
        chk("rst_instret", bus.instret_cnt,     64'd0);

        // Good ebreak after five normal commits
        do_reset();
        for (int i = 0; i < 5; i++) cyc(2'b01, 32'h8000_0000 + 32'(4*i), NOP, 0, 0, 0, 0, 0);
        push(3'd1, 32'h8000_0014, 32'd0, 1'b1, 64'd5, 64'd6);
        cyc(2'b01, 32'h8000_0014, EBRK, 0, 0, 0, 0, 32'd0);
        wait_done();

        // Bad exit code
        do_reset();
        cyc(2'b01, 32'h8000_0000, NOP, 0, 0, 0, 0, 0);
        cyc(2'b01, 32'h8000_0004, NOP, 0, 0, 0, 0, 0);
        push(3'd2, 32'h8000_0008, 32'h2A, 1'b0, 64'd2, 64'd3);
        cyc(2'b01, 32'h8000_0008, EBRK, 0, 0, 0, 0, 32'h2A);
        wait_done();

        // ch0 normal, ch1 illegal: ch0 retires
        do_reset();
        push(3'd3, 32'h104, 32'd1, 1'b0, 64'd1, 64'd1);
        cyc(2'b11, 32'h100, NOP, 0, 32'h104, ILL, 0, 0);
        wait_done();

        // ch0 illegal beats younger ebreak on ch1
        do_reset();
        push(3'd3, 32'h200, 32'd1, 1'b0, 64'd0, 64'd1);
        cyc(2'b11, 32'h200, ILL, 0, 32'h204, EBRK, 0, 0);
        wait_done();

        // Watchdog with no commits fires on the 9th RUN edge
        do_reset();
        push(3'd5, 32'd0, 32'd1, 1'b0, 64'd0, 64'd9);
        wait_done();

        // A commit on edge 6 restarts the watchdog: fires on edge 15
        do_reset();
        push(3'd5, 32'h300, 32'd1, 1'b0, 64'd1, 64'd15);
        for (int i = 0; i < 5; i++) cyc(2'b00, 0, 0, 0, 0, 0, 0, 0);
        cyc(2'b01, 32'h300, NOP, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(2'b00, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("wd_no_early_halt", 64'(bus.halt), 64'd0);
        wait_done();

        // Overflow outranks illegal; later commits are ignored
        do_reset();
        push(3'd4, 32'h400, 32'd1, 1'b0, 64'd0, 64'd1);
        cyc(2'b01, 32'h400, ILL, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(2'b11, 32'h500, EBRK, 0, 32'h504, NOP, 1, 32'h7);
        @(negedge clk);
        chk("frz_cause",   64'(bus.halt_cause), 64'd4);
        chk("frz_pc",      64'(bus.halt_pc),    64'h400);
        chk("frz_code",    64'(bus.halt_code),  64'd1);
        chk("frz_cycles",  bus.cycle_cnt,       64'd1);
        chk("frz_instret", bus.instret_cnt,     64'd0);
        chk("frz_done",    64'(bus.done),       64'd1);

        // Reset while draining clears everything and restarts counters
        do_reset();
        cyc(2'b01, 32'h600, NOP, 0, 0, 0, 0, 0);
        push(3'd1, 32'h604, 32'd0, 1'b1, 64'd1, 64'd2);
        cyc(2'b01, 32'h604, EBRK, 0, 0, 0, 0, 32'd0);
        @(negedge clk);
        chk("drain_halt", 64'(bus.halt), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("dr_rst_halt",    64'(bus.halt),       64'd0);
        chk("dr_rst_cause",   64'(bus.halt_cause), 64'd0);
        chk("dr_rst_pc",      64'(bus.halt_pc),    64'd0);
        chk("dr_rst_cycles",  bus.cycle_cnt,       64'd0);
        for (int i = 0; i < 3; i++) cyc(2'b11, 32'h700, NOP, 0, 32'h704, NOP, 0, 0);
        @(negedge clk);
        chk("restart_cycles",  bus.cycle_cnt,   64'd3);
        chk("restart_instret", bus.instret_cnt, 64'd6);
        chk("restart_halt",    64'(bus.halt),   64'd0);
        for (int i = 0; i < 4; i++) @(negedge clk);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1);
    end

endmodule
